// File: rtl/dbg_pkg.sv
// Shared constants for the CSR/trap debug monitor: tvec mode encodings
// and the mask that strips the mode bits to get the handler entry address.
package dbg_pkg;

    localparam logic [1:0] TVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] TVEC_MODE_VECTORED = 2'b01;

    // Handler entry = tvec with the two mode bits cleared
    localparam logic [63:0] TVEC_ALIGN_MASK = {{62{1'b1}}, 2'b00};

endpackage

// File: rtl/dbg_csr_trace_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, async clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Next count with saturation at all-ones instead of wrapping
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        if (&v)
            return v;
        else
            return v + W'(1);
    endfunction

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc)
            cnt <= sat_inc(cnt);
    end

endmodule

// File: rtl/dbg_csr_trace.sv
// Passive trap monitor for the CSR/trap unit: per-privilege trap counters,
// a last-trap record and sticky error flags. Drives nothing into the core.
module dbg_csr_trace
    import dbg_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int VERBOSE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      pc,
    input  logic             except,
    input  logic             medeleg,
    input  logic [63:0]      tvec,
    output logic [CNT_W-1:0] trap_cnt_s,
    output logic [CNT_W-1:0] trap_cnt_m,
    output logic             last_valid,
    output logic [63:0]      last_pc,
    output logic [63:0]      last_tvec,
    output logic             last_deleg,
    output logic             err_tvec_zero,
    output logic             err_tvec_mode,
    output logic             err_trap_loop
);

    logic evt_s_p0;
    logic evt_m_p0;
    logic tvec_zero_p0;
    logic tvec_mode_p0;
    logic trap_loop_p0;

    assign evt_s_p0 = except &  medeleg;
    assign evt_m_p0 = except & ~medeleg;

    // Event-cycle checks; the loop check deliberately uses the record as it
    // stood before this event so back-to-back traps compare against the first.
    always_comb begin
        tvec_zero_p0 = (tvec == 64'h0);
        tvec_mode_p0 = (tvec[1:0] != TVEC_MODE_DIRECT) &&
                       (tvec[1:0] != TVEC_MODE_VECTORED);
        trap_loop_p0 = last_valid && (pc == (last_tvec & TVEC_ALIGN_MASK));
    end

    // ---- stage boundary: event sampled -> counters/record/flags ----

    sat_counter #(.W(CNT_W)) u_cnt_s (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (evt_s_p0),
        .cnt   (trap_cnt_s)
    );

    sat_counter #(.W(CNT_W)) u_cnt_m (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (evt_m_p0),
        .cnt   (trap_cnt_m)
    );

    // Last-trap record, overwritten on every event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid <= 1'b0;
            last_pc    <= '0;
            last_tvec  <= '0;
            last_deleg <= 1'b0;
        end else if (except) begin
            last_valid <= 1'b1;
            last_pc    <= pc;
            last_tvec  <= tvec;
            last_deleg <= medeleg;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_tvec_zero <= 1'b0;
            err_tvec_mode <= 1'b0;
            err_trap_loop <= 1'b0;
        end else if (except) begin
            err_tvec_zero <= err_tvec_zero | tvec_zero_p0;
            err_tvec_mode <= err_tvec_mode | tvec_mode_p0;
            err_trap_loop <= err_trap_loop | trap_loop_p0;
        end
    end

    generate
        if (VERBOSE != 0) begin : g_verbose
`ifndef SYNTHESIS
            // Simulation-only trace of each trap and each flag's first assertion
            always @(posedge clk) begin
                if (rst_n && except) begin
                    $display("%0t trap %s pc=%h tvec=%h", $time,
                             medeleg ? "S" : "M", pc, tvec);
                    if (tvec_zero_p0 && !err_tvec_zero)
                        $display("%0t warning: err_tvec_zero set", $time);
                    if (tvec_mode_p0 && !err_tvec_mode)
                        $display("%0t warning: err_tvec_mode set", $time);
                    if (trap_loop_p0 && !err_trap_loop)
                        $display("%0t warning: err_trap_loop set", $time);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dbg_csr_trace.sv
// Scoreboard bench for dbg_csr_trace: a reference model pushes expected
// post-edge state when stimulus is driven; it is popped and compared after
// the edge. A second instance with CNT_W=4 exposes counter saturation.
module tb_dbg_csr_trace;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc = '0;
    logic        except = 1'b0;
    logic        medeleg = 1'b0;
    logic [63:0] tvec = '0;

    logic [31:0] trap_cnt_s, trap_cnt_m;
    logic        last_valid, last_deleg;
    logic [63:0] last_pc, last_tvec;
    logic        err_tvec_zero, err_tvec_mode, err_trap_loop;

    logic [3:0]  n_cnt_s, n_cnt_m;
    logic        n_last_valid, n_last_deleg;
    logic [63:0] n_last_pc, n_last_tvec;
    logic        n_err_zero, n_err_mode, n_err_loop;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] cs;
        logic [31:0] cm;
        logic [3:0]  cm4;
        logic [3:0]  cs4;
        logic        lv;
        logic [63:0] lp;
        logic [63:0] lt;
        logic        ld;
        logic        ez;
        logic        em;
        logic        el;
    } exp_t;

    exp_t m;
    exp_t sbq[$];

    always #5 clk = ~clk;

    dbg_csr_trace #(.CNT_W(32), .VERBOSE(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .except        (except),
        .medeleg       (medeleg),
        .tvec          (tvec),
        .trap_cnt_s    (trap_cnt_s),
        .trap_cnt_m    (trap_cnt_m),
        .last_valid    (last_valid),
        .last_pc       (last_pc),
        .last_tvec     (last_tvec),
        .last_deleg    (last_deleg),
        .err_tvec_zero (err_tvec_zero),
        .err_tvec_mode (err_tvec_mode),
        .err_trap_loop (err_trap_loop)
    );

    dbg_csr_trace #(.CNT_W(4), .VERBOSE(0)) dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .except        (except),
        .medeleg       (medeleg),
        .tvec          (tvec),
        .trap_cnt_s    (n_cnt_s),
        .trap_cnt_m    (n_cnt_m),
        .last_valid    (n_last_valid),
        .last_pc       (n_last_pc),
        .last_tvec     (n_last_tvec),
        .last_deleg    (n_last_deleg),
        .err_tvec_zero (n_err_zero),
        .err_tvec_mode (n_err_mode),
        .err_trap_loop (n_err_loop)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic compare_all(input exp_t e);
        chk("trap_cnt_s",    64'(trap_cnt_s),    64'(e.cs));
        chk("trap_cnt_m",    64'(trap_cnt_m),    64'(e.cm));
        chk("last_valid",    64'(last_valid),    64'(e.lv));
        chk("last_pc",       last_pc,            e.lp);
        chk("last_tvec",     last_tvec,          e.lt);
        chk("last_deleg",    64'(last_deleg),    64'(e.ld));
        chk("err_tvec_zero", 64'(err_tvec_zero), 64'(e.ez));
        chk("err_tvec_mode", 64'(err_tvec_mode), 64'(e.em));
        chk("err_trap_loop", 64'(err_trap_loop), 64'(e.el));
        chk("w4_cnt_m",      64'(n_cnt_m),       64'(e.cm4));
        chk("w4_cnt_s",      64'(n_cnt_s),       64'(e.cs4));
    endtask

    // Reference model of one clock edge
    task automatic model_step(input logic ex, input logic dl,
                              input logic [63:0] p, input logic [63:0] t);
        logic [63:0] entry;
        if (ex) begin
            entry = {m.lt[63:2], 2'b00};
            if (m.lv && (p == entry)) m.el = 1'b1;
            if (t == 64'h0)           m.ez = 1'b1;
            if (t[1])                 m.em = 1'b1;
            if (dl) begin
                if (m.cs  != 32'hFFFF_FFFF) m.cs  = m.cs + 1;
                if (m.cs4 != 4'hF)          m.cs4 = m.cs4 + 1;
            end else begin
                if (m.cm  != 32'hFFFF_FFFF) m.cm  = m.cm + 1;
                if (m.cm4 != 4'hF)          m.cm4 = m.cm4 + 1;
            end
            m.lv = 1'b1;
            m.lp = p;
            m.lt = t;
            m.ld = dl;
        end
    endtask

    task automatic step(input logic ex, input logic dl,
                        input logic [63:0] p, input logic [63:0] t);
        exp_t e;
        @(negedge clk);
        except  = ex;
        medeleg = dl;
        pc      = p;
        tvec    = t;
        model_step(ex, dl, p, t);
        sbq.push_back(m);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            compare_all(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        except = 1'b0;
        m = '0;
        sbq.delete();
        #1;
        compare_all(m);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m = '0;
        // Power-on reset, then idle
        repeat (2) @(negedge clk);
        compare_all(m);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'h0, 64'h0);

        // Single M-mode trap
        step(1'b1, 1'b0, 64'h8000_0010, 64'h8000_0100);
        step(1'b0, 1'b0, 64'h0, 64'h0);

        // Back-to-back S-mode traps with vectored tvec
        step(1'b1, 1'b1, 64'h100, 64'h8020_0001);
        step(1'b1, 1'b1, 64'h104, 64'h8020_0001);

        // Zero and reserved-mode tvec, then clean traps: flags stay sticky
        step(1'b1, 1'b0, 64'h200, 64'h0);
        step(1'b1, 1'b1, 64'h300, 64'h2);
        step(1'b1, 1'b0, 64'h500, 64'h9000_0000);
        step(1'b1, 1'b1, 64'h504, 64'h9000_0001);
        step(1'b0, 1'b0, 64'h0, 64'h0);

        // Trap loop: second trap raised at handler entry of the first
        step(1'b1, 1'b0, 64'h400, 64'h8000_0101);
        step(1'b1, 1'b0, 64'h8000_0100, 64'h9000_0000);
        step(1'b0, 1'b0, 64'h0, 64'h0);

        // Reset clears everything; near-miss pc must not flag a loop
        do_reset();
        step(1'b1, 1'b0, 64'h400, 64'h8000_0101);
        step(1'b1, 1'b0, 64'h8000_0104, 64'h9000_0000);
        step(1'b0, 1'b0, 64'h0, 64'h0);

        // Mixed random traffic
        for (int i = 0; i < 30; i++) begin
            logic [63:0] rp, rt;
            rp = {32'h0, $urandom};
            rt = {32'h0, $urandom} & 64'hFFFF_FFF3;
            if (i % 7 == 3) rp = {m.lt[63:2], 2'b00};
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rp, rt);
        end

        // Saturation of the 4-bit instance via 20 M-mode traps
        do_reset();
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 64'h2000 + 64'(i * 4), 64'h1000);

        // Asynchronous reset mid-burst, with an event pending that must be lost
        step(1'b1, 1'b0, 64'h3000, 64'h1000);
        @(negedge clk);
        except  = 1'b1;
        medeleg = 1'b0;
        pc      = 64'h3004;
        tvec    = 64'h1000;
        #2;
        rst_n = 1'b0;
        #1;
        m = '0;
        sbq.delete();
        compare_all(m);
        @(negedge clk);
        except = 1'b0;
        rst_n  = 1'b1;
        step(1'b0, 1'b0, 64'h0, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_csr_trace.md
Name: dbg_csr_trace

Overview:
Passive debug monitor attached to the CSR/trap unit. It samples trap events (except, medeleg, pc, target vector) every clock, keeps per-privilege trap counters and a last-trap record, and raises sticky error flags for malformed trap vectors and trap loops. It drives nothing back into the core; all outputs are observation-only for benches and debug ports.

Parameters:
CNT_W, 32, width of each trap counter
VERBOSE, 1, when 1 emit a simulation-only $display line per trap; 0 silent (no effect on synthesizable logic)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc  input  64  PC of the instruction raising the trap
except  input  1  trap taken this cycle
medeleg  input  1  1 = trap delegated to S-mode (stvec), 0 = M-mode (mtvec)
tvec  input  64  trap target vector selected this cycle
trap_cnt_s  output  CNT_W  number of delegated (S-mode) traps
trap_cnt_m  output  CNT_W  number of M-mode traps
last_valid  output  1  at least one trap recorded since reset
last_pc  output  64  pc of most recent trap
last_tvec  output  64  tvec of most recent trap
last_deleg  output  1  medeleg of most recent trap
err_tvec_zero  output  1  sticky: a trap used tvec == 0
err_tvec_mode  output  1  sticky: a trap used reserved tvec mode (tvec[1] == 1)
err_trap_loop  output  1  sticky: a trap was raised at the entry address of the previous trap

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Reset: all counters 0, last_valid 0, last_pc/last_tvec 0, last_deleg 0, all err_* 0. Reset takes effect immediately regardless of clock, including in the cycle an except is asserted; that event is lost.
- Inputs are sampled on the rising clk edge. A trap event is except == 1 at the edge. All outputs are registered and update one edge after the event (latency 1). There is no handshake; every cycle with except high is a separate event, including back-to-back cycles.
- Counters:
  - On an event with medeleg == 1, trap_cnt_s increments; with medeleg == 0, trap_cnt_m increments.
  - Each counter saturates at all-ones and holds there (no wrap).
- Record: on an event, last_pc <= pc, last_tvec <= tvec, last_deleg <= medeleg, last_valid <= 1. Without an event these hold.
- Error checks are evaluated on the event cycle. Flags are sticky until reset.
  - err_tvec_zero sets when tvec == 64'h0.
  - err_tvec_mode sets when tvec[1] == 1. Mode 00 (direct) and 01 (vectored) are legal.
  - err_trap_loop sets when last_valid == 1 and pc == {last_tvec[63:2], 2'b00}, i.e. the handler entry itself trapped. The comparison uses the pre-update record, so two consecutive events compare against the first.
  - Several flags may set in the same cycle.
- Simulation only (translate_off region): when VERBOSE == 1, each event prints time, "S"/"M", pc and tvec in hex; each error flag's 0->1 transition prints one warning line.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package dbg_pkg: 2-bit tvec mode encodings (DIRECT = 2'b00, VECTORED = 2'b01), and the alignment mask constant used for the loop compare.
- A single sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output cnt), instantiated twice for the S and M counters. Everything else stays in dbg_csr_trace.

Test Plan:
- Reset, then hold except = 0 for 10 cycles -> all counters 0, last_valid 0, all err_* 0.
- except = 1 for one cycle with medeleg = 0, pc = 0x8000_0010, tvec = 0x8000_0100 -> next edge: trap_cnt_m = 1, trap_cnt_s = 0, last_pc = 0x8000_0010, last_tvec = 0x8000_0100, last_deleg = 0, last_valid = 1, no errors.
- Two back-to-back events with medeleg = 1, tvec = 0x8020_0001 (vectored), pcs 0x100 then 0x104 -> trap_cnt_s = 2, last_pc = 0x104, err_tvec_mode stays 0.
- Event with tvec = 0 -> err_tvec_zero = 1. Event with tvec = 0x2 -> err_tvec_mode = 1. Both remain 1 after further clean events; both clear only on rst_n low.
- Event with tvec = 0x8000_0101, then an event with pc = 0x8000_0100 -> err_trap_loop = 1. Repeat with pc = 0x8000_0104 after reset -> err_trap_loop stays 0.
- Force a CNT_W = 4 instance through 20 M-mode events -> trap_cnt_m saturates at 15. Asserting rst_n low mid-burst clears it to 0 asynchronously, before the next clock edge.
